// File: rtl/rot_cnt_fsm.sv
// rot_cnt_fsm: quadrature detent sequencer for the rotation counter.
// Ports: clk, rst (sync, active-low), quad_ctl[1:0], run -> enable, up_down, error.
// Emits one count strobe plus direction per full Gray detent cycle.
// Skipped codes go to an error state that waits for the 00 rest code.
// Optional input deglitch filter: define QUAD_FILTER_EN (uses FILT_CYCLES).
module rot_cnt_fsm #(
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] quad_ctl,
  input  logic       run,
  output logic       enable,
  output logic       up_down,
  output logic       error
);

  localparam logic [3:0] S_SYNC = 4'd0;
  localparam logic [3:0] S_IDLE = 4'd1;
  localparam logic [3:0] S_CW1  = 4'd2;
  localparam logic [3:0] S_CW2  = 4'd3;
  localparam logic [3:0] S_CW3  = 4'd4;
  localparam logic [3:0] S_CCW1 = 4'd5;
  localparam logic [3:0] S_CCW2 = 4'd6;
  localparam logic [3:0] S_CCW3 = 4'd7;
  localparam logic [3:0] S_ERR  = 4'd8;

  if (FILT_CYCLES < 2 || FILT_CYCLES > 15) begin : g_bad_filt
    $error("FILT_CYCLES out of range 2..15");
  end

  logic [1:0] code;

`ifdef QUAD_FILTER_EN
  logic [1:0] code_q, code_d;
  logic [1:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;

  // cnt counts consecutive samples of cand that differ
  // from the held code; a full run replaces the held code.
  always_comb begin
    code_d = code_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (quad_ctl == code_q) begin
      cnt_d = '0;
    end else if (quad_ctl == cand_q) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cand_d = quad_ctl;
      cnt_d  = 4'd1;
    end
    if (cnt_d == 4'(FILT_CYCLES)) begin
      code_d = quad_ctl;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      code_q <= 2'b00;
      cand_q <= 2'b00;
      cnt_q  <= '0;
    end else begin
      code_q <= code_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign code = code_q;
`else
  assign code = quad_ctl;
`endif

  logic [3:0] state_q, state_d;
  logic       en_q, en_d;
  logic       up_q, up_d;
  logic       err_q, err_d;
  logic       done_cw, done_ccw;

  always_comb begin
    state_d  = state_q;
    done_cw  = 1'b0;
    done_ccw = 1'b0;
    unique case (state_q)
      S_SYNC: begin
        if (code == 2'b00) state_d = S_IDLE;
      end
      S_IDLE: begin
        unique case (code)
          2'b01:   state_d = S_CW1;
          2'b10:   state_d = S_CCW1;
          2'b11:   state_d = S_ERR;
          default: state_d = S_IDLE;
        endcase
      end
      S_CW1: begin
        unique case (code)
          2'b11:   state_d = S_CW2;
          2'b00:   state_d = S_IDLE;
          2'b10:   state_d = S_ERR;
          default: state_d = S_CW1;
        endcase
      end
      S_CW2: begin
        unique case (code)
          2'b10:   state_d = S_CW3;
          2'b01:   state_d = S_CW1;
          2'b00:   state_d = S_ERR;
          default: state_d = S_CW2;
        endcase
      end
      S_CW3: begin
        unique case (code)
          2'b00: begin
            state_d = S_IDLE;
            done_cw = 1'b1;
          end
          2'b11:   state_d = S_CW2;
          2'b01:   state_d = S_ERR;
          default: state_d = S_CW3;
        endcase
      end
      S_CCW1: begin
        unique case (code)
          2'b11:   state_d = S_CCW2;
          2'b00:   state_d = S_IDLE;
          2'b01:   state_d = S_ERR;
          default: state_d = S_CCW1;
        endcase
      end
      S_CCW2: begin
        unique case (code)
          2'b01:   state_d = S_CCW3;
          2'b10:   state_d = S_CCW1;
          2'b00:   state_d = S_ERR;
          default: state_d = S_CCW2;
        endcase
      end
      S_CCW3: begin
        unique case (code)
          2'b00: begin
            state_d  = S_IDLE;
            done_ccw = 1'b1;
          end
          2'b11:   state_d = S_CCW2;
          2'b10:   state_d = S_ERR;
          default: state_d = S_CCW3;
        endcase
      end
      S_ERR: begin
        if (code == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_SYNC;
    endcase
  end

  // With run low a completed detent is dropped and
  // the direction keeps its last counted value.
  always_comb begin
    en_d  = run & (done_cw | done_ccw);
    up_d  = up_q;
    err_d = (state_d == S_ERR);
    if (en_d) up_d = done_cw;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_SYNC;
      en_q    <= 1'b0;
      up_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      up_q    <= up_d;
      err_q   <= err_d;
    end
  end

  assign enable  = en_q;
  assign up_down = up_q;
  assign error   = err_q;

endmodule

// File: tb/tb_rot_cnt_fsm.sv
// tb_rot_cnt_fsm: directed and random checks of rot_cnt_fsm
// against a displacement-based model of the detent rules.
module tb_rot_cnt_fsm;

  localparam int F = 4;
`ifdef QUAD_FILTER_EN
  localparam int H = F + 2;
`else
  localparam int H = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [1:0] quad_ctl;
  logic       enable;
  logic       up_down;
  logic       error;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  // model: mode 0=sync 1=tracking 2=error
  int         m_mode;
  int         m_d;
  bit         m_en;
  bit         m_up;
  bit         m_err;
  logic [1:0] m_held;
  logic [1:0] hist[$];
  logic [1:0] gray[4];

  rot_cnt_fsm #(.FILT_CYCLES(F)) dut (
    .clk(clk),
    .rst(rst),
    .quad_ctl(quad_ctl),
    .run(run),
    .enable(enable),
    .up_down(up_down),
    .error(error)
  );

  always #5 clk = ~clk;

  function automatic int pos(input logic [1:0] c);
    case (c)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_d    = 0;
    m_en   = 0;
    m_up   = 1;
    m_err  = 0;
    m_held = 2'b00;
    hist.delete();
  endtask

  // Position along the Gray cycle relative to rest:
  // +1..+3 part of a CW detent, -1..-3 part of a CCW one.
  task automatic model_fsm(input logic [1:0] c, input bit r);
    int cur;
    int delta;
    m_en = 0;
    if (m_mode != 1) begin
      if (c == 2'b00) begin
        m_mode = 1;
        m_d    = 0;
      end
    end else begin
      cur   = ((m_d % 4) + 4) % 4;
      delta = (pos(c) - cur + 4) % 4;
      if (delta == 2) begin
        m_mode = 2;
      end else if (delta == 1) begin
        m_d = m_d + 1;
        if (m_d == 4) begin
          m_d = 0;
          if (r) begin
            m_en = 1;
            m_up = 1;
          end
        end
      end else if (delta == 3) begin
        m_d = m_d - 1;
        if (m_d == -4) begin
          m_d = 0;
          if (r) begin
            m_en = 1;
            m_up = 0;
          end
        end
      end
    end
    m_err = (m_mode == 2);
  endtask

  task automatic model_edge(input logic [1:0] q, input bit r, input bit nrst);
    bit same;
    if (!nrst) begin
      model_reset();
    end else begin
`ifdef QUAD_FILTER_EN
      model_fsm(m_held, r);
      hist.push_back(q);
      if (hist.size() > F) void'(hist.pop_front());
      if (hist.size() == F) begin
        same = 1;
        foreach (hist[i]) if (hist[i] != q) same = 0;
        if (same) m_held = q;
      end
`else
      same = 0;
      model_fsm(q, r);
`endif
    end
  endtask

  task automatic step(input logic [1:0] q, input bit r, input bit nrst);
    quad_ctl = q;
    run      = r;
    rst      = nrst;
    @(posedge clk);
    model_edge(q, r, nrst);
    #1;
    if (enable === 1'b1) pulses++;
    tests++;
    assert (enable === m_en) else begin
      fails++;
      $error("FAIL enable t=%0t got %b exp %b", $time, enable, m_en);
    end
    tests++;
    assert (up_down === m_up) else begin
      fails++;
      $error("FAIL up_down t=%0t got %b exp %b", $time, up_down, m_up);
    end
    tests++;
    assert (error === m_err) else begin
      fails++;
      $error("FAIL error t=%0t got %b exp %b", $time, error, m_err);
    end
  endtask

  task automatic hold(input logic [1:0] q, input bit r, input int n);
    for (int i = 0; i < n; i++) step(q, r, 1'b1);
  endtask

  task automatic cw(input bit r);
    hold(2'b01, r, H);
    hold(2'b11, r, H);
    hold(2'b10, r, H);
    hold(2'b00, r, H);
  endtask

  task automatic ccw(input bit r);
    hold(2'b10, r, H);
    hold(2'b11, r, H);
    hold(2'b01, r, H);
    hold(2'b00, r, H);
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got == exp) else begin
      fails++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  initial begin
    int p;
    int k;
    int n;
    bit r;
    gray[0] = 2'b00;
    gray[1] = 2'b01;
    gray[2] = 2'b11;
    gray[3] = 2'b10;
    model_reset();

    // reset with a non-rest code, then release into SYNC
    step(2'b10, 1'b1, 1'b0);
    step(2'b10, 1'b1, 1'b0);
    hold(2'b10, 1'b1, H);
    chk("sync_no_err", int'(error), 0);
    hold(2'b00, 1'b1, H);

    pulses = 0;
    cw(1'b1);
    chk("cw_pulses", pulses, 1);
    chk("cw_dir", int'(up_down), 1);

    pulses = 0;
    ccw(1'b1);
    chk("ccw_pulses", pulses, 1);
    chk("ccw_dir", int'(up_down), 0);
    pulses = 0;
    ccw(1'b1);
    ccw(1'b1);
    chk("ccw2_pulses", pulses, 2);

    step(2'b11, 1'b1, 1'b1);
    chk("skip_err", int'(error), 1);
    hold(2'b11, 1'b1, H);
`ifdef QUAD_FILTER_EN
    hold(2'b00, 1'b1, H);
`else
    step(2'b00, 1'b1, 1'b1);
    chk("err_clear", int'(error), 0);
    hold(2'b00, 1'b1, H - 1);
`endif
    pulses = 0;
    cw(1'b1);
    chk("cw_after_err", pulses, 1);
    chk("cw_after_err_dir", int'(up_down), 1);

    pulses = 0;
    hold(2'b01, 1'b1, H);
    hold(2'b11, 1'b1, H);
    hold(2'b01, 1'b1, H);
    hold(2'b00, 1'b1, H);
    chk("reverse_pulses", pulses, 0);
    chk("reverse_err", int'(error), 0);
    ccw(1'b1);
    pulses = 0;
    cw(1'b0);
    chk("run0_pulses", pulses, 0);
    chk("run0_dir", int'(up_down), 0);

    // single-cycle glitch, then a held code
    step(2'b01, 1'b1, 1'b1);
    hold(2'b00, 1'b1, H);
    hold(2'b01, 1'b1, H);
    hold(2'b00, 1'b1, H);

    // reset mid-sequence
    hold(2'b01, 1'b1, H);
    hold(2'b11, 1'b1, H);
    step(2'b11, 1'b1, 1'b0);
    hold(2'b00, 1'b1, H);

    p = 0;
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 99);
      r = ($urandom_range(0, 9) < 8);
      n = $urandom_range(1, H + 2);
      if (k < 70) p = (p + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4;
      else if (k < 80) p = p;
      else if (k < 96) p = $urandom_range(0, 3);
      else begin
        step(gray[p], r, 1'b0);
        continue;
      end
      hold(gray[p], r, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
